// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: deframes {inst,addr,data} frames into one-clk register-file strobes.
// Strobes land 4 clk after the deciding sck rise; no backpressure, the SPI master paces all traffic.
module spi_frame_slave #(
   parameter int INST_WIDTH = 1,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck_i,
   input  logic                  sdi_i,
   input  logic                  cs_ni,
   output logic                  sdo_o,
   output logic                  sdo_oe_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  wr_en_o,
   output logic                  rd_en_o,
   input  logic [DATA_WIDTH-1:0] rdata_i
);

   localparam int FW  = INST_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam int HW  = INST_WIDTH + ADDR_WIDTH;
   localparam int RXW = (DATA_WIDTH > HW) ? DATA_WIDTH : HW;
   localparam int CW  = 5;
   localparam logic [CW-1:0] CNT_HDR_LAST = CW'(HW - 1);
   localparam logic [CW-1:0] CNT_SH_FIRST = CW'(HW + 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(FW - 1);
   localparam logic [CW-1:0] CNT_FULL     = CW'(FW);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   logic       sck_s1_q, sck_s2_q, sck_s3_q;
   logic       sdi_s1_q, sdi_s2_q;
   logic       cs_s1_q, cs_s2_q, cs_s3_q;
   logic       sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;
   logic [1:0] vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_s3_q   <= 1'b0;
         sdi_s1_q   <= 1'b0;
         sdi_s2_q   <= 1'b0;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_s3_q    <= 1'b1;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
         vld_q      <= '0;
      end else begin
         sck_s1_q   <= sck_i;
         sck_s2_q   <= sck_s1_q;
         sck_s3_q   <= sck_s2_q;
         sdi_s1_q   <= sdi_i;
         sdi_s2_q   <= sdi_s1_q;
         cs_s1_q    <= cs_ni;
         cs_s2_q    <= cs_s1_q;
         cs_s3_q    <= cs_s2_q;
         sck_rise_q <= sck_s2_q & ~sck_s3_q;
         sck_fall_q <= ~sck_s2_q & sck_s3_q;
         cs_rise_q  <= cs_s2_q & ~cs_s3_q;
         cs_fall_q  <= ~cs_s2_q & cs_s3_q;
         vld_q      <= {vld_q[0], 1'b1};
      end
   end

   state_t                  state_q;
   logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [RXW-2:0]          rx_q;
   logic [RXW-1:0]          rx_d;
   logic [DATA_WIDTH-1:0]   tx_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    wr_q, rd_q;
   logic                    armed_q;

   // rx_d/bit_cnt_d already include the bit arriving on this sck rise, so
   // decisions taken "at bit_cnt N" happen on the same edge that reaches N.
   always_comb begin
      rx_d      = {rx_q, sdi_s2_q};
      bit_cnt_d = bit_cnt_q;
      if (bit_cnt_q != CNT_FULL) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         // A frame already in flight when reset released must not be picked up halfway.
         armed_q <= armed_q | (vld_q[1] & cs_s2_q);

         if (cs_rise_q) begin
            state_q <= IDLE;
         end else if (cs_fall_q && armed_q) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
         end else if (sck_rise_q && state_q != IDLE) begin
            rx_q      <= rx_d[RXW-2:0];
            bit_cnt_q <= bit_cnt_d;
            case (state_q)
               CMD: begin
                  if (bit_cnt_q == CNT_HDR_LAST) begin
                     addr_q <= rx_d[ADDR_WIDTH-1:0];
                     if (rx_d[ADDR_WIDTH +: INST_WIDTH] == INST_WIDTH'(1)) begin
                        rd_q    <= 1'b1;
                        state_q <= RD;
                     end else begin
                        state_q <= WR;
                     end
                  end
               end
               RD: begin
                  if (bit_cnt_q == CNT_LAST) begin
                     state_q <= DONE;
                  end
               end
               WR: begin
                  if (bit_cnt_q == CNT_LAST) begin
                     wdata_q <= rx_d[DATA_WIDTH-1:0];
                     wr_q    <= 1'b1;
                     state_q <= DONE;
                  end
               end
               default: begin
               end
            endcase
         end else if (sck_fall_q && state_q == RD &&
                      bit_cnt_q >= CNT_SH_FIRST && bit_cnt_q <= CNT_LAST) begin
            tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
         end

         // Register file answers combinationally from addr_o while rd_en_o is high.
         if (rd_q && state_q == RD) begin
            tx_q <= rdata_i;
         end
      end
   end

   assign sdo_o    = (state_q == RD) ? tx_q[DATA_WIDTH-1] : 1'b0;
   assign sdo_oe_o = ~cs_s2_q;
   assign addr_o   = addr_q;
   assign wdata_o  = wdata_q;
   assign wr_en_o  = wr_q;
   assign rd_en_o  = rd_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: directed frame table, reset-mid-frame sequence, then random frames vs a register-map model.
module tb_spi_frame_slave;

   logic       clk;
   logic       rst_n;
   logic       sck_i, sdi_i, cs_ni;
   logic       sdo_o, sdo_oe_o, wr_en_o, rd_en_o;
   logic [6:0] addr_o;
   logic [7:0] wdata_o, rdata_i;

   logic [7:0] rf     [128];
   logic [7:0] ref_rf [128];

   int n_chk = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int both_cnt = 0;
   logic [6:0] wr_addr_log, rd_addr_log;
   logic [7:0] wr_data_log;
   logic [6:0] exp_addr;
   logic [7:0] exp_wdata;

   typedef struct {
      bit         inst;
      logic [6:0] addr;
      logic [7:0] data;
      int         nbits;
      int         gap;
      bit         pre;
      bit         exp_wr;
      bit         exp_rd;
      logic [7:0] exp_miso;
   } vec_t;

   spi_frame_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck_i    (sck_i),
      .sdi_i    (sdi_i),
      .cs_ni    (cs_ni),
      .sdo_o    (sdo_o),
      .sdo_oe_o (sdo_oe_o),
      .addr_o   (addr_o),
      .wdata_o  (wdata_o),
      .wr_en_o  (wr_en_o),
      .rd_en_o  (rd_en_o),
      .rdata_i  (rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rdata_i = rd_en_o ? rf[addr_o] : 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en_o) begin
            wr_cnt++;
            wr_addr_log = addr_o;
            wr_data_log = wdata_o;
            rf[addr_o]  = wdata_o;
         end
         if (rd_en_o) begin
            rd_cnt++;
            rd_addr_log = addr_o;
         end
         if (wr_en_o && rd_en_o) both_cnt++;
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] d);
      rf[a]     = d;
      ref_rf[a] = d;
   endtask

   // Master: 7 clk per sck phase, samples sdo on each rise, optional reset pulse after fall rst_at.
   task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int rst_at,
                           input bit exp_wr, input bit exp_rd, input logic [7:0] exp_miso,
                           output logic [7:0] miso);
      miso  = 8'h00;
      cs_ni = 1'b0;
      clks(5);
      for (int i = 0; i < nbits; i++) begin
         int r;
         r = i + 1;
         sdi_i = (i < 16) ? frame[15-i] : 1'b0;
         clks(7);
         sck_i = 1'b1;
         if (i == 0) chk("sdo_oe_in_frame", 32'(sdo_oe_o), 32'd1);
         if (i >= 8 && i < 16) miso[15-i] = sdo_o;
         for (int j = 1; j <= 7; j++) begin
            clks(1);
            if (exp_rd && r == 8) begin
               if (j == 3) chk("rd_en_early", 32'(rd_en_o), 32'd0);
               if (j == 4) begin
                  chk("rd_en_latency", 32'(rd_en_o), 32'd1);
                  chk("rd_addr", 32'(addr_o), 32'(frame[14:8]));
                  chk("sdo_before_load", 32'(sdo_o), 32'd0);
               end
               if (j == 5) begin
                  chk("rd_en_width", 32'(rd_en_o), 32'd0);
                  chk("sdo_load", 32'(sdo_o), 32'(exp_miso[7]));
               end
            end
            if (exp_wr && r == 16) begin
               if (j == 3) chk("wr_en_early", 32'(wr_en_o), 32'd0);
               if (j == 4) begin
                  chk("wr_en_latency", 32'(wr_en_o), 32'd1);
                  chk("wr_data", 32'(wdata_o), 32'(frame[7:0]));
               end
               if (j == 5) chk("wr_en_width", 32'(wr_en_o), 32'd0);
            end
         end
         sck_i = 1'b0;
         for (int j = 1; j <= 7; j++) begin
            clks(1);
            if (exp_rd && r >= 9 && r <= 15) begin
               if (j == 3) chk($sformatf("sdo_hold_fall%0d", r), 32'(sdo_o), 32'(exp_miso[16-r]));
               if (j == 4) chk($sformatf("sdo_shift_fall%0d", r), 32'(sdo_o), 32'(exp_miso[15-r]));
            end
         end
         if (r == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_sdo", 32'(sdo_o), 32'd0);
            chk("rst_sdo_oe", 32'(sdo_oe_o), 32'd0);
            chk("rst_addr", 32'(addr_o), 32'd0);
            chk("rst_wdata", 32'(wdata_o), 32'd0);
            chk("rst_wr_en", 32'(wr_en_o), 32'd0);
            chk("rst_rd_en", 32'(rd_en_o), 32'd0);
            clks(2);
            rst_n = 1'b1;
         end
      end
      clks(5);
      cs_ni = 1'b1;
   endtask

   task automatic run_frame(input string tag, input bit inst, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits, input int gap, input int rst_at,
                            input bit exp_wr, input bit exp_rd, input logic [7:0] exp_miso);
      int wr0, rd0;
      logic [7:0] miso;
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      spi_xfer({inst, addr, data}, nbits, rst_at, exp_wr, exp_rd, exp_miso, miso);
      clks(gap);
      chk({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      chk({tag, "_rd_count"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      if (exp_wr) begin
         chk({tag, "_wr_addr"}, 32'(wr_addr_log), 32'(addr));
         chk({tag, "_wr_data"}, 32'(wr_data_log), 32'(data));
      end
      if (exp_rd) chk({tag, "_rd_addr"}, 32'(rd_addr_log), 32'(addr));
      if (exp_rd && nbits >= 16) chk({tag, "_miso"}, 32'(miso), 32'(exp_miso));
      if (rst_at != 0) begin
         exp_addr  = 7'h00;
         exp_wdata = 8'h00;
      end else begin
         if (nbits >= 8) exp_addr = addr;
         if (exp_wr) begin
            exp_wdata    = data;
            ref_rf[addr] = data;
         end
      end
      chk({tag, "_addr_hold"}, 32'(addr_o), 32'(exp_addr));
      chk({tag, "_wdata_hold"}, 32'(wdata_o), 32'(exp_wdata));
      chk({tag, "_sdo_oe_idle"}, 32'(sdo_oe_o), 32'd0);
      chk({tag, "_sdo_idle"}, 32'(sdo_o), 32'd0);
   endtask

   initial begin
      vec_t tbl [8];
      tbl[0] = '{1'b0, 7'h05, 8'hA5, 16, 6, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 7'h0C, 8'h3C, 16, 6, 1'b1, 1'b0, 1'b1, 8'h3C};
      tbl[2] = '{1'b0, 7'h03, 8'h77, 10, 6, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 7'h03, 8'h11, 16, 6, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 7'h07, 8'hFF, 18, 6, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[5] = '{1'b0, 7'h01, 8'h5A, 16, 4, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[6] = '{1'b1, 7'h01, 8'h00, 16, 6, 1'b0, 1'b0, 1'b1, 8'h5A};
      tbl[7] = '{1'b1, 7'h12, 8'hC3, 12, 6, 1'b1, 1'b0, 1'b1, 8'hC3};

      for (int k = 0; k < 128; k++) begin
         rf[k]     = 8'(k * 37 + 5);
         ref_rf[k] = 8'(k * 37 + 5);
      end
      exp_addr  = 7'h00;
      exp_wdata = 8'h00;
      rst_n = 1'b0;
      sck_i = 1'b0;
      sdi_i = 1'b0;
      cs_ni = 1'b1;
      clks(3);
      chk("reset_sdo", 32'(sdo_o), 32'd0);
      chk("reset_sdo_oe", 32'(sdo_oe_o), 32'd0);
      chk("reset_addr", 32'(addr_o), 32'd0);
      chk("reset_wdata", 32'(wdata_o), 32'd0);
      chk("reset_wr_en", 32'(wr_en_o), 32'd0);
      chk("reset_rd_en", 32'(rd_en_o), 32'd0);
      rst_n = 1'b1;
      clks(5);

      for (int v = 0; v < 8; v++) begin
         if (tbl[v].pre) preload(tbl[v].addr, tbl[v].data);
         run_frame($sformatf("vec%0d", v), tbl[v].inst, tbl[v].addr, tbl[v].data, tbl[v].nbits,
                   tbl[v].gap, 0, tbl[v].exp_wr, tbl[v].exp_rd, tbl[v].exp_miso);
      end

      run_frame("rst_mid_write", 1'b0, 7'h2A, 8'h99, 16, 6, 12, 1'b0, 1'b0, 8'h00);
      preload(7'h00, 8'h00);
      run_frame("read_after_rst", 1'b1, 7'h00, 8'h00, 16, 6, 0, 1'b0, 1'b1, 8'h00);

      for (int n = 0; n < 24; n++) begin
         bit         inst;
         logic [6:0] addr;
         logic [7:0] data;
         int         nbits;
         int         gap;
         bit         ewr;
         bit         erd;
         inst  = 1'($urandom_range(0, 1));
         addr  = 7'($urandom_range(0, 7));
         data  = 8'($urandom);
         nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
         gap   = int'($urandom_range(4, 9));
         ewr   = !inst && nbits >= 16;
         erd   = inst && nbits >= 8;
         run_frame($sformatf("rnd%0d", n), inst, addr, data, nbits, gap, 0, ewr, erd, ref_rf[addr]);
      end

      chk("strobe_overlap", 32'(both_cnt), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
